// File: rtl/sensor_pkg.sv
// Shared types and constants for the sensor frame transmitter.
// Frame layout: header, type, four LSB-first words, checksum.
package sensor_pkg;

  localparam logic [7:0] HEADER = 8'h55;
  localparam int FRAME_BYTES = 11;

  typedef enum logic [7:0] {
    MSG_ACCEL = 8'h51,
    MSG_ANGLE = 8'h53
  } sensor_msg_t;

  typedef enum logic [2:0] {
    IDLE,
    GAP,
    START,
    DATA,
    STOP
  } tx_state_t;

  function automatic logic [7:0] frame_byte(
    input logic [3:0]       idx,
    input logic [7:0]       hdr,
    input logic [7:0]       typ,
    input logic [3:0][15:0] d,
    input logic [7:0]       cs
  );
    logic [2:0]  j;
    logic [15:0] w;
    j = 3'(idx - 4'd2);
    w = d[j[2:1]];
    unique case (1'b1)
      idx == 4'd0: frame_byte = hdr;
      idx == 4'd1: frame_byte = typ;
      idx == 4'(FRAME_BYTES - 1): frame_byte = cs;
      default: frame_byte = j[0] ? w[15:8] : w[7:0];
    endcase
  endfunction

endpackage

// File: rtl/sensor_frame_tx_if.sv
// Frame request handshake plus UART line and status.
// master = frame requester, slave = transmitter.
interface sensor_frame_tx_if;
  logic             in_valid;
  logic             in_ready;
  logic [7:0]       msg_type;
  logic [3:0][15:0] data;
  logic             tx;
  logic             busy;
  logic             done;

  modport master (
    output in_valid, msg_type, data,
    input  in_ready, tx, busy, done
  );

  modport slave (
    input  in_valid, msg_type, data,
    output in_ready, tx, busy, done
  );
endinterface

// File: rtl/sensor_frame_tx_uart_byte_tx.sv
// Byte serializer: idle gap, start, 8 data bits LSB first, stop.
// ready/done are high in the last stop cycle so bytes chain seamlessly.
module uart_byte_tx
  import sensor_pkg::*;
#(
  parameter int CLKS_PER_BIT = 8,
  parameter int IDLE_BITS    = 1
) (
  input  logic       clk_uart,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] din,
  output logic       tx,
  output logic       ready,
  output logic       done
);

  localparam int GAP_LEN = IDLE_BITS * CLKS_PER_BIT;
  localparam int CNT_MAX =
    (GAP_LEN > CLKS_PER_BIT) ? GAP_LEN : CLKS_PER_BIT;
  localparam int CW = $clog2(CNT_MAX + 1);
  localparam logic [CW-1:0] BIT_END = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] PRE_END = CW'(CLKS_PER_BIT - 2);
  localparam logic [CW-1:0] GAP_END = CW'(GAP_LEN - 1);

  tx_state_t     state;
  logic [CW-1:0] cnt;
  logic [2:0]    bitn;
  logic [7:0]    sh;
  logic          launch;

  assign launch = start && ready;

  always_ff @(posedge clk_uart) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      bitn  <= '0;
      sh    <= '0;
      tx    <= 1'b1;
      ready <= 1'b0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      cnt  <= cnt + 1'b1;
      if (launch) begin
        state <= (GAP_LEN > 0) ? GAP : START;
        tx    <= (GAP_LEN > 0);
        cnt   <= '0;
        sh    <= din;
        ready <= 1'b0;
      end else begin
        unique case (state)
          IDLE: begin
            ready <= 1'b1;
            cnt   <= '0;
          end
          GAP: if (cnt == GAP_END) begin
            state <= START;
            tx    <= 1'b0;
            cnt   <= '0;
          end
          START: if (cnt == BIT_END) begin
            state <= DATA;
            tx    <= sh[0];
            sh    <= sh >> 1;
            bitn  <= '0;
            cnt   <= '0;
          end
          DATA: if (cnt == BIT_END) begin
            cnt <= '0;
            if (bitn == 3'd7) begin
              state <= STOP;
              tx    <= 1'b1;
            end else begin
              tx   <= sh[0];
              sh   <= sh >> 1;
              bitn <= bitn + 3'd1;
            end
          end
          STOP: begin
            // flag the final stop cycle one edge early
            if (cnt == PRE_END) begin
              done  <= 1'b1;
              ready <= 1'b1;
            end
            if (cnt == BIT_END) begin
              state <= IDLE;
              cnt   <= '0;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: rtl/sensor_frame_tx.sv
// Sensor frame transmitter: frame sequencing, byte mux, checksum.
// Next byte is handed over in the last stop cycle of the previous one.
module sensor_frame_tx #(
  parameter int         CLKS_PER_BIT = 8,
  parameter int         IDLE_BITS    = 1,
  parameter logic [7:0] HEADER       = sensor_pkg::HEADER
) (
  input logic              clk_uart,
  input logic              rst,
  sensor_frame_tx_if.slave bus
);

  localparam logic [3:0] LAST = 4'(sensor_pkg::FRAME_BYTES - 1);

  logic [7:0]       msg_r;
  logic [7:0]       csum;
  logic [7:0]       cur;
  logic [3:0][15:0] data_r;
  logic [3:0]       idx;
  logic [3:0]       nidx;
  logic             frame;
  logic             last;
  logic             accept;
  logic             next_b;
  logic             b_ready;
  logic             b_done;
  logic             done_i;
  logic             ready_i;
  logic             tx_line;

  assign last    = idx == LAST;
  assign done_i  = frame && last && b_done;
  assign ready_i = b_ready && (!frame || last);
  assign accept  = bus.in_valid && ready_i;
  assign next_b  = frame && b_done && !last;
  assign nidx    = idx + 4'd1;
  assign cur     = accept ? HEADER :
    sensor_pkg::frame_byte(nidx, HEADER, msg_r, data_r, csum);

  assign bus.in_ready = ready_i;
  assign bus.done     = done_i;
  assign bus.busy     = frame && !done_i;
  assign bus.tx       = tx_line;

  always_ff @(posedge clk_uart) begin
    if (rst) begin
      frame  <= 1'b0;
      idx    <= '0;
      csum   <= '0;
      msg_r  <= '0;
      data_r <= '0;
    end else if (accept) begin
      frame  <= 1'b1;
      idx    <= '0;
      csum   <= HEADER;
      msg_r  <= bus.msg_type;
      data_r <= bus.data;
    end else if (next_b) begin
      idx <= nidx;
      if (nidx != LAST) csum <= csum + cur;
    end else if (done_i) begin
      frame <= 1'b0;
    end
  end

  uart_byte_tx #(
    .CLKS_PER_BIT(CLKS_PER_BIT),
    .IDLE_BITS   (IDLE_BITS)
  ) u_byte (
    .clk_uart(clk_uart),
    .rst     (rst),
    .start   (accept || next_b),
    .din     (cur),
    .tx      (tx_line),
    .ready   (b_ready),
    .done    (b_done)
  );

endmodule
